// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Build option: REGFILE_R0_PROTECT_EN (see regfile_wr_arbiter.sv).
package regfile_ctrl_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 4;

  typedef enum logic {
    ARB   = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Two-way round-robin grant with its own priority pointer.
// The pointer moves to the other requester only when a transfer happens.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_ptr_q == REQ0) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = gnt[0] ? REQ1 : REQ0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= REQ0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file's single write port between two writers and
// runs a zero-fill sweep. Build option: REGFILE_R0_PROTECT_EN drops writes to r0.
module regfile_wr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              sweep_start,
  output logic              sweep_busy,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              load,
  output logic [ADDR_W-1:0] Caddr,
  output logic [DATA_W-1:0] C
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [DATA_W-1:0] c_q, c_d;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              xfer;
  logic              wr_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Handshake: a requester holds req/addr/data until it sees gnt; the write
  // transfers on the rising edge where req && gnt, after which req may change.
  assign arb_en = (state_q == ARB) && !sweep_start && !clear;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (clear),
    .req     ({req1, req0}),
    .enable  (arb_en),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign xfer     = |gnt;
  assign sel_addr = gnt[1] ? addr1 : addr0;
  assign sel_data = gnt[1] ? data1 : data0;

`ifdef REGFILE_R0_PROTECT_EN
  assign wr_en = (sel_addr != '0);
`else
  assign wr_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (sweep_start) state_d = SWEEP;
      SWEEP:   if (caddr_q == LAST_ADDR) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    load_d  = 1'b0;
    caddr_d = caddr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        if (sweep_start) begin
          load_d  = 1'b1;
          caddr_d = '0;
          c_d     = '0;
          cnt_d   = ADDR_W'(1);
        end else if (xfer && wr_en) begin
          load_d  = 1'b1;
          caddr_d = sel_addr;
          c_d     = sel_data;
        end
      end
      SWEEP: begin
        // The counter wraps to zero alongside the final address, leaving it at its idle value.
        if (caddr_q != LAST_ADDR) begin
          load_d  = 1'b1;
          caddr_d = cnt_q;
          c_d     = '0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: load_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q   <= '0;
      load_q  <= 1'b0;
      caddr_q <= '0;
      c_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      caddr_q <= caddr_d;
      c_q     <= c_d;
    end
  end

  assign sweep_busy = (state_q == SWEEP);
  assign load       = load_q;
  assign Caddr      = caddr_q;
  assign C          = c_q;

endmodule
